// File: rtl/board_move_master.sv
// Avalon-MM master that performs one chess move on a 64 x 4-bit board RAM:
// read source, read destination, check legality, write destination, clear source.
module board_move_master #(
  parameter logic [3:0] EMPTY_CODE = 4'hC,
  parameter int         RD_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       MOVE_VALID,
  output logic       MOVE_READY,
  input  logic [5:0] MOVE_SRC,
  input  logic [5:0] MOVE_DST,
  output logic       MOVE_DONE,
  output logic       MOVE_ERR,
  output logic [3:0] MOVED_PIECE,
  output logic [3:0] CAPTURED_PIECE,
  output logic       AVL_CS,
  output logic       AVL_READ,
  output logic       AVL_WRITE,
  output logic [5:0] AVL_ADDR,
  output logic [3:0] AVL_WRITEDATA,
  input  logic [3:0] AVL_READDATA
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SRC, S_WAIT_SRC, S_RD_DST, S_WAIT_DST, S_WR_DST, S_WR_SRC, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      src_q, src_d, dst_q, dst_d;
  logic [3:0]      moved_q, moved_d, captured_q, captured_d;
  logic            err_q, err_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            wait_last;

  assign wait_last = (wait_q == CW'(RD_LATENCY - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      moved_q    <= EMPTY_CODE;
      captured_q <= EMPTY_CODE;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      moved_q    <= moved_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    moved_d    = moved_q;
    captured_d = captured_q;
    err_d      = err_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (MOVE_VALID) begin
          src_d   = MOVE_SRC;
          dst_d   = MOVE_DST;
          err_d   = (MOVE_SRC == MOVE_DST);
          state_d = (MOVE_SRC == MOVE_DST) ? S_DONE : S_RD_SRC;
        end
      end
      S_RD_SRC: begin
        wait_d  = '0;
        state_d = S_WAIT_SRC;
      end
      S_WAIT_SRC: begin
        if (wait_last) begin
          moved_d = AVL_READDATA;
          if (AVL_READDATA == EMPTY_CODE) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RD_DST;
          end
        end else begin
          wait_d = CW'(wait_q + 1'b1);
        end
      end
      S_RD_DST: begin
        wait_d  = '0;
        state_d = S_WAIT_DST;
      end
      S_WAIT_DST: begin
        if (wait_last) begin
          captured_d = AVL_READDATA;
          // Capturing a piece of the mover's own colour is illegal.
          if ((AVL_READDATA != EMPTY_CODE) && (AVL_READDATA[0] == moved_q[0])) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WR_DST;
          end
        end else begin
          wait_d = CW'(wait_q + 1'b1);
        end
      end
      S_WR_DST: state_d = S_WR_SRC;
      S_WR_SRC: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MOVE_READY    = (state_q == S_IDLE);
    MOVE_DONE     = (state_q == S_DONE);
    MOVE_ERR      = (state_q == S_DONE) && err_q;
    AVL_CS        = 1'b0;
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_ADDR      = '0;
    AVL_WRITEDATA = '0;
    case (state_q)
      S_RD_SRC: begin
        AVL_CS   = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = src_q;
      end
      S_RD_DST: begin
        AVL_CS   = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = dst_q;
      end
      S_WR_DST: begin
        AVL_CS        = 1'b1;
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = dst_q;
        AVL_WRITEDATA = moved_q;
      end
      S_WR_SRC: begin
        AVL_CS        = 1'b1;
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = src_q;
        AVL_WRITEDATA = EMPTY_CODE;
      end
      default: ;
    endcase
  end

  assign MOVED_PIECE    = moved_q;
  assign CAPTURED_PIECE = captured_q;

endmodule

// File: tb/tb_board_move_master.sv
// Directed bench for board_move_master: two instances (read latency 1 and 2),
// each with its own behavioural board RAM slave.
module tb_board_move_master;

  localparam logic [3:0] EC = 4'hC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] move_src = '0, move_dst = '0;
  logic       valid1 = 1'b0, valid2 = 1'b0;

  logic       ready1, done1, err1, cs1, rd1, wr1;
  logic [3:0] moved1, cap1, wdata1, rdata1;
  logic [5:0] addr1;
  logic       ready2, done2, err2, cs2, rd2, wr2;
  logic [3:0] moved2, cap2, wdata2, rdata2;
  logic [5:0] addr2;

  logic [3:0] mem1 [64];
  logic [3:0] mem2 [64];
  logic [3:0] pipe1, pipe2a, pipe2b;

  always #5 clk = ~clk;

  board_move_master #(.EMPTY_CODE(EC), .RD_LATENCY(1)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .MOVE_VALID(valid1), .MOVE_READY(ready1),
    .MOVE_SRC(move_src), .MOVE_DST(move_dst), .MOVE_DONE(done1), .MOVE_ERR(err1),
    .MOVED_PIECE(moved1), .CAPTURED_PIECE(cap1), .AVL_CS(cs1), .AVL_READ(rd1),
    .AVL_WRITE(wr1), .AVL_ADDR(addr1), .AVL_WRITEDATA(wdata1), .AVL_READDATA(rdata1));

  board_move_master #(.EMPTY_CODE(EC), .RD_LATENCY(2)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .MOVE_VALID(valid2), .MOVE_READY(ready2),
    .MOVE_SRC(move_src), .MOVE_DST(move_dst), .MOVE_DONE(done2), .MOVE_ERR(err2),
    .MOVED_PIECE(moved2), .CAPTURED_PIECE(cap2), .AVL_CS(cs2), .AVL_READ(rd2),
    .AVL_WRITE(wr2), .AVL_ADDR(addr2), .AVL_WRITEDATA(wdata2), .AVL_READDATA(rdata2));

  // Slave models: latency 1 for dut1, latency 2 for dut2.
  always @(posedge clk) begin
    if (cs1 && wr1) mem1[addr1] = wdata1;
    if (cs1 && rd1) pipe1 <= mem1[addr1];
    if (cs2 && wr2) mem2[addr2] = wdata2;
    if (cs2 && rd2) pipe2a <= mem2[addr2];
    pipe2b <= pipe2a;
  end
  assign rdata1 = pipe1;
  assign rdata2 = pipe2b;

  // Monitor mux selects which instance the move task observes.
  logic       sel = 1'b0;
  logic       m_ready, m_done, m_err, m_cs, m_rd, m_wr;
  logic [3:0] m_moved, m_cap, m_wdata;
  logic [5:0] m_addr;
  assign m_ready = sel ? ready2 : ready1;
  assign m_done  = sel ? done2  : done1;
  assign m_err   = sel ? err2   : err1;
  assign m_cs    = sel ? cs2    : cs1;
  assign m_rd    = sel ? rd2    : rd1;
  assign m_wr    = sel ? wr2    : wr1;
  assign m_moved = sel ? moved2 : moved1;
  assign m_cap   = sel ? cap2   : cap1;
  assign m_wdata = sel ? wdata2 : wdata1;
  assign m_addr  = sel ? addr2  : addr1;

  int n_cmp = 0;
  int n_bad = 0;

  int         done_cyc, cs_cycles, both_cycles, log_n;
  logic       r_err;
  logic [3:0] r_moved, r_cap;
  logic       log_w [8];
  logic [5:0] log_a [8];
  logic [3:0] log_d [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_board();
    for (int i = 0; i < 64; i++) begin
      mem1[i] = EC;
      mem2[i] = EC;
    end
  endtask

  // Issues one request from an idle negedge; cycle 1 is the cycle after the accept edge.
  task automatic do_move(input logic use2, input logic [5:0] s, input logic [5:0] d);
    sel = use2;
    done_cyc = -1; cs_cycles = 0; both_cycles = 0; log_n = 0;
    r_err = 1'bx; r_moved = 'x; r_cap = 'x;
    @(negedge clk);
    check("ready_before_move", {31'd0, m_ready}, 32'd1);
    move_src = s;
    move_dst = d;
    if (use2) valid2 = 1'b1; else valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
    move_src = ~s;
    move_dst = ~d;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (m_cs) begin
        cs_cycles++;
        if (m_rd && m_wr) both_cycles++;
        if (log_n < 8) begin
          log_w[log_n] = m_wr;
          log_a[log_n] = m_addr;
          log_d[log_n] = m_wdata;
          log_n++;
        end
      end
      if (m_done) begin
        done_cyc = cyc;
        r_err    = m_err;
        r_moved  = m_moved;
        r_cap    = m_cap;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic found;
    init_board();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready1}, 32'd1);
    check("rst_done_err", {30'd0, done1, err1}, 32'd0);
    check("rst_strobes", {29'd0, cs1, rd1, wr1}, 32'd0);
    check("rst_addr_wdata", {22'd0, addr1, wdata1}, 32'd0);
    check("rst_moved_cap", {24'd0, moved1, cap1}, {24'd0, EC, EC});
    rst_n = 1'b1;

    // Legal pawn push to an empty square; request inputs scrambled after accept.
    mem1[52] = 4'h1; mem1[36] = EC;
    do_move(1'b0, 6'd52, 6'd36);
    check("t1_done_cyc", done_cyc, 32'd7);
    check("t1_err", {31'd0, r_err}, 32'd0);
    check("t1_moved", {28'd0, r_moved}, 32'h1);
    check("t1_captured", {28'd0, r_cap}, {28'd0, EC});
    check("t1_nbus", log_n, 32'd4);
    check("t1_op0", {25'd0, log_w[0], log_a[0]}, {25'd0, 1'b0, 6'd52});
    check("t1_op1", {25'd0, log_w[1], log_a[1]}, {25'd0, 1'b0, 6'd36});
    check("t1_op2", {21'd0, log_w[2], log_a[2], log_d[2]}, {21'd0, 1'b1, 6'd36, 4'h1});
    check("t1_op3", {21'd0, log_w[3], log_a[3], log_d[3]}, {21'd0, 1'b1, 6'd52, EC});
    check("t1_rd_wr_same", both_cycles, 32'd0);
    check("t1_board", {24'd0, mem1[36], mem1[52]}, {24'd0, 4'h1, EC});

    // Empty source square.
    do_move(1'b0, 6'd20, 6'd28);
    check("t2_done_cyc", done_cyc, 32'd3);
    check("t2_err", {31'd0, r_err}, 32'd1);
    check("t2_nbus", log_n, 32'd1);
    check("t2_read20", {25'd0, log_w[0], log_a[0]}, {25'd0, 1'b0, 6'd20});
    check("t2_board", {24'd0, mem1[20], mem1[28]}, {24'd0, EC, EC});

    // Capture of own-colour piece.
    mem1[56] = 4'h7; mem1[48] = 4'h1;
    do_move(1'b0, 6'd56, 6'd48);
    check("t3_done_cyc", done_cyc, 32'd5);
    check("t3_err", {31'd0, r_err}, 32'd1);
    check("t3_nbus", log_n, 32'd2);
    check("t3_pieces", {24'd0, r_moved, r_cap}, 32'h71);
    check("t3_board", {24'd0, mem1[56], mem1[48]}, 32'h71);

    // Legal capture of an opposite-colour piece.
    mem1[52] = 4'h1; mem1[36] = 4'h0;
    do_move(1'b0, 6'd52, 6'd36);
    check("t4_done_cyc", done_cyc, 32'd7);
    check("t4_err", {31'd0, r_err}, 32'd0);
    check("t4_captured", {28'd0, r_cap}, 32'h0);
    check("t4_op2", {21'd0, log_w[2], log_a[2], log_d[2]}, {21'd0, 1'b1, 6'd36, 4'h1});
    check("t4_op3", {21'd0, log_w[3], log_a[3], log_d[3]}, {21'd0, 1'b1, 6'd52, EC});

    // Source equals destination.
    do_move(1'b0, 6'd10, 6'd10);
    check("t5_done_cyc", done_cyc, 32'd1);
    check("t5_err", {31'd0, r_err}, 32'd1);
    check("t5_cs_cycles", cs_cycles, 32'd0);

    // Reset asserted during WR_DST of a legal move.
    mem1[52] = 4'h1; mem1[36] = EC;
    @(negedge clk);
    sel = 1'b0;
    move_src = 6'd52; move_dst = 6'd36; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    found = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cs1 && wr1 && addr1 == 6'd36) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reached_wr_dst", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_strobes", {29'd0, cs1, rd1, wr1}, 32'd0);
    check("t6_ready", {31'd0, ready1}, 32'd1);
    check("t6_src_kept", {28'd0, mem1[52]}, 32'h1);
    check("t6_dst_written", {28'd0, mem1[36]}, 32'h1);
    rst_n = 1'b1;

    // Read latency 2 instance.
    mem2[52] = 4'h1; mem2[36] = EC;
    do_move(1'b1, 6'd52, 6'd36);
    check("t7_done_cyc", done_cyc, 32'd9);
    check("t7_err", {31'd0, r_err}, 32'd0);
    check("t7_pieces", {24'd0, r_moved, r_cap}, {24'd0, 4'h1, EC});
    check("t7_board", {24'd0, mem2[36], mem2[52]}, {24'd0, 4'h1, EC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
